// File: rtl/cpu_pkg.sv
// Shared encodings for simple_cpu and its instruction sequencer.
// The instruction class is carried in the top two bits of every instruction word.
package cpu_pkg;

  localparam int INSTR_WIDTH = 20;

  typedef enum logic [1:0] {
    CLS_NOP   = 2'b00,
    CLS_ALU   = 2'b01,
    CLS_LOAD  = 2'b10,
    CLS_STORE = 2'b11
  } instr_class_t;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'b00,
    SEQ_RUN  = 2'b01,
    SEQ_DONE = 2'b10
  } seq_state_t;

endpackage

// File: rtl/instr_store.sv
// Program store: one synchronous write port and one combinational read port.
module instr_store #(
  parameter int WIDTH      = 20,
  parameter int ADDR_BITS  = 5
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_BITS];

  // NOTE: the array has no reset on purpose; resetting it would turn it into
  // flops with a reset mux on every bit, and a loaded program must survive rst_n.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction-issue front end: presents program-store words to simple_cpu,
// each held for a number of cycles that depends on its instruction class.
module instr_sequencer #(
  parameter int INSTR_WIDTH    = cpu_pkg::INSTR_WIDTH,
  parameter int PROG_ADDR_BITS = 5,
  parameter int ALU_CYCLES     = 3,
  parameter int STORE_CYCLES   = 3,
  parameter int LOAD_CYCLES    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      prog_we,
  input  logic [PROG_ADDR_BITS-1:0] prog_addr,
  input  logic [INSTR_WIDTH-1:0]    prog_data,
  input  logic [PROG_ADDR_BITS:0]   prog_len,
  input  logic                      start,
  input  logic                      halt,
  output logic [INSTR_WIDTH-1:0]    instruction,
  output logic [PROG_ADDR_BITS-1:0] pc,
  output logic                      busy,
  output logic                      done
);

  import cpu_pkg::*;

  localparam int MAX_A    = (ALU_CYCLES > STORE_CYCLES) ? ALU_CYCLES : STORE_CYCLES;
  localparam int MAX_HOLD = (MAX_A > LOAD_CYCLES) ? MAX_A : LOAD_CYCLES;
  localparam int CNT_W    = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [PROG_ADDR_BITS:0] DEPTH = (PROG_ADDR_BITS+1)'(2**PROG_ADDR_BITS);

  seq_state_t                state_q, state_d;
  logic [PROG_ADDR_BITS-1:0] pc_d;
  logic [PROG_ADDR_BITS:0]   len_q, len_d, len_sat, pc_inc;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [INSTR_WIDTH-1:0]    instr_d, rd_data;
  logic [PROG_ADDR_BITS-1:0] rd_addr;
  logic                      store_we;

  // Remaining hold edges after the one that loads the instruction.
  function automatic logic [CNT_W-1:0] hold_m1(input logic [1:0] cls);
    case (instr_class_t'(cls))
      CLS_ALU:   return CNT_W'(ALU_CYCLES - 1);
      CLS_STORE: return CNT_W'(STORE_CYCLES - 1);
      CLS_LOAD:  return CNT_W'(LOAD_CYCLES - 1);
      default:   return '0;
    endcase
  endfunction

  assign len_sat  = (prog_len > DEPTH) ? DEPTH : prog_len;
  assign pc_inc   = {1'b0, pc} + (PROG_ADDR_BITS+1)'(1);
  assign rd_addr  = (state_q == SEQ_RUN) ? pc_inc[PROG_ADDR_BITS-1:0] : '0;
  assign store_we = prog_we && (state_q != SEQ_RUN);

  instr_store #(
    .WIDTH     (INSTR_WIDTH),
    .ADDR_BITS (PROG_ADDR_BITS)
  ) u_store (
    .clk   (clk),
    .we    (store_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // NOTE: every variable gets its hold value first so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    cnt_d   = cnt_q;
    len_d   = len_q;
    instr_d = instruction;
    if (halt) begin
      state_d = SEQ_IDLE;
      pc_d    = '0;
      cnt_d   = '0;
      instr_d = '0;
    end else begin
      case (state_q)
        SEQ_RUN: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (pc_inc < len_q) begin
            pc_d    = pc_inc[PROG_ADDR_BITS-1:0];
            instr_d = rd_data;
            cnt_d   = hold_m1(rd_data[INSTR_WIDTH-1 -: 2]);
          end else begin
            state_d = SEQ_DONE;
            instr_d = '0;
          end
        end
        default: begin
          if (start) begin
            pc_d  = '0;
            len_d = len_sat;
            if (len_sat != '0) begin
              state_d = SEQ_RUN;
              instr_d = rd_data;
              cnt_d   = hold_m1(rd_data[INSTR_WIDTH-1 -: 2]);
            end else begin
              state_d = SEQ_DONE;
              instr_d = '0;
              cnt_d   = '0;
            end
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEQ_IDLE;
      pc          <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      instruction <= '0;
    end else begin
      state_q     <= state_d;
      pc          <= pc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      instruction <= instr_d;
    end
  end

  assign busy = (state_q == SEQ_RUN);
  assign done = (state_q == SEQ_DONE);

endmodule
